// File: rtl/seg_scan_ctrl.sv
// Display scheduler for a 4-digit 7-segment path: round-robin grant of two 16-bit
// sources, frame-aligned swap-in, dead-time digit scan and leading-zero blanking.
module seg_scan_ctrl #(
  parameter int SCAN_DIV = 1000,
  parameter int DEAD     = 16,
  parameter int HOLD     = 50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  input  logic [31:0] req_value,
  output logic [1:0]  req_ready,
  input  logic        lz_en,
  output logic [3:0]  nibble,
  output logic [3:0]  digit,
  output logic        owner
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_DEAD  = CW'(DEAD);
  localparam logic [HW-1:0] HCNT_INIT = HW'((HOLD > 0) ? HOLD - 1 : 0);

  typedef enum logic [1:0] {ST_OPEN, ST_PEND, ST_HOLD} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [1:0]    idx_reg, idx_next;
  logic [15:0]   disp_reg, disp_next;
  logic [15:0]   shadow_reg, shadow_next;
  logic          pend_owner_reg, pend_owner_next;
  logic          rr_reg, rr_next;
  logic          owner_reg, owner_next;
  logic [HW-1:0] hcnt_reg, hcnt_next;
  logic [3:0]    nibble_reg, nibble_next;
  logic [3:0]    digit_reg, digit_next;

  logic          cnt_wrap;
  logic          frame_end;
  logic [1:0]    grant;
  logic [3:0]    blank;

  assign cnt_wrap  = (cnt_reg == CNT_LAST);
  assign frame_end = cnt_wrap && (idx_reg == 2'd3);

  // Digit k is blanked when every digit from k upward is zero; digit 0 always shows.
  assign blank[0] = 1'b0;
  for (genvar gi = 1; gi < 4; gi++) begin : g_blank
    assign blank[gi] = lz_en && (disp_reg[15:4*gi] == '0);
  end

  always_comb begin
    cnt_next    = cnt_wrap ? '0 : cnt_reg + CW'(1);
    idx_next    = cnt_wrap ? idx_reg + 2'd1 : idx_reg;
    nibble_next = disp_reg[4*idx_reg +: 4];
    digit_next  = 4'b0000;
    if (cnt_reg >= CNT_DEAD && !blank[idx_reg])
      digit_next = 4'b0001 << idx_reg;
  end

  always_comb begin
    state_next      = state_reg;
    shadow_next     = shadow_reg;
    pend_owner_next = pend_owner_reg;
    rr_next         = rr_reg;
    disp_next       = disp_reg;
    owner_next      = owner_reg;
    hcnt_next       = hcnt_reg;
    grant           = 2'b00;
    case (state_reg)
      ST_OPEN: begin
        if (rr_reg == 1'b0)
          grant = req_valid[0] ? 2'b01 : (req_valid[1] ? 2'b10 : 2'b00);
        else
          grant = req_valid[1] ? 2'b10 : (req_valid[0] ? 2'b01 : 2'b00);
        if (|(grant & req_valid)) begin
          shadow_next     = grant[1] ? req_value[31:16] : req_value[15:0];
          pend_owner_next = grant[1];
          rr_next         = ~grant[1];
          state_next      = ST_PEND;
        end
      end
      ST_PEND: begin
        // Swap on the same edge as the idx 3->0 wrap so a frame never mixes values.
        if (frame_end) begin
          disp_next  = shadow_reg;
          owner_next = pend_owner_reg;
          if (HOLD == 0) begin
            state_next = ST_OPEN;
          end else begin
            state_next = ST_HOLD;
            hcnt_next  = HCNT_INIT;
          end
        end
      end
      ST_HOLD: begin
        if (hcnt_reg == '0)
          state_next = ST_OPEN;
        else
          hcnt_next = hcnt_reg - HW'(1);
      end
      default: state_next = ST_OPEN;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg      <= ST_OPEN;
      cnt_reg        <= '0;
      idx_reg        <= '0;
      disp_reg       <= '0;
      shadow_reg     <= '0;
      pend_owner_reg <= 1'b0;
      rr_reg         <= 1'b0;
      owner_reg      <= 1'b0;
      hcnt_reg       <= '0;
      nibble_reg     <= '0;
      digit_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      idx_reg        <= idx_next;
      disp_reg       <= disp_next;
      shadow_reg     <= shadow_next;
      pend_owner_reg <= pend_owner_next;
      rr_reg         <= rr_next;
      owner_reg      <= owner_next;
      hcnt_reg       <= hcnt_next;
      nibble_reg     <= nibble_next;
      digit_reg      <= digit_next;
    end
  end

  // Grant is combinational; keep it quiet while reset is held.
  assign req_ready = reset ? 2'b00 : grant;
  assign nibble    = nibble_reg;
  assign digit     = digit_reg;
  assign owner     = owner_reg;

endmodule
